bus_fifo_slave: RTL and testbench



---
 rtl/bus_fifo_slave.sv | 175 +++++++++++++++++
 tb/tb_bus_fifo_slave.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_fifo_slave.sv
// Bus slave with TX/RX byte FIFOs, status/control registers and an optional interrupt.
// Define BUS_FIFO_IRQ_EN to store the CTRL interrupt-enable bit and drive irq.
module bus_fifo_slave #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs_,
    input  logic        asel_,
    input  logic        rw,
    input  logic [29:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        rdy_,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    typedef enum logic {S_IDLE = 1'b0, S_ACK = 1'b1} state_t;

    state_t         r_state, w_state_next;
    logic [31:0]    r_rd_data;
    logic [7:0]     r_tx_mem [DEPTH];
    logic [7:0]     r_rx_mem [DEPTH];
    logic [AW-1:0]  r_tx_wr_ptr, r_tx_rd_ptr, r_rx_wr_ptr, r_rx_rd_ptr;
    logic [AW:0]    r_tx_count, r_rx_count;
    logic           r_rx_ovf, r_tx_ovf, r_rx_udf;

    logic w_access, w_wr, w_rd, w_ctrl_wr;
    logic w_tx_push_req, w_tx_push, w_tx_pop, w_tx_ovf_evt, w_flush_tx;
    logic w_rx_pop_req, w_rx_pop, w_rx_push, w_rx_ovf_evt, w_rx_udf_evt, w_flush_rx;
    logic w_clr, w_ie;
    logic w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
    logic [31:0] w_status, w_rd_value;
    logic w_unused;

    assign w_unused = ^{addr[29:2], wr_data[31:8], wr_data[2]};

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_access) w_state_next = S_ACK;
            S_ACK:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_access      = (r_state == S_IDLE) && !cs_ && !asel_;
    assign w_wr          = w_access && !rw;
    assign w_rd          = w_access && rw;
    assign w_ctrl_wr     = w_wr && (addr[1:0] == 2'd2);
    assign w_flush_tx    = w_ctrl_wr && wr_data[0];
    assign w_flush_rx    = w_ctrl_wr && wr_data[1];
    assign w_clr         = w_ctrl_wr && wr_data[3];

    assign w_tx_empty    = (r_tx_count == '0);
    assign w_tx_full     = (r_tx_count == CNT_FULL);
    assign w_rx_empty    = (r_rx_count == '0);
    assign w_rx_full     = (r_rx_count == CNT_FULL);

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign w_tx_push_req = w_wr && (addr[1:0] == 2'd0);
    assign w_tx_pop      = !w_tx_empty && tx_ready;
    assign w_tx_push     = w_tx_push_req && !w_flush_tx && (!w_tx_full || w_tx_pop);
    assign w_tx_ovf_evt  = w_tx_push_req && !w_flush_tx && w_tx_full && !w_tx_pop;

    assign w_rx_pop_req  = w_rd && (addr[1:0] == 2'd0);
    assign w_rx_pop      = w_rx_pop_req && !w_rx_empty;
    assign w_rx_udf_evt  = w_rx_pop_req && w_rx_empty;
    assign w_rx_push     = rx_valid && !w_flush_rx && (!w_rx_full || w_rx_pop);
    assign w_rx_ovf_evt  = rx_valid && !w_flush_rx && w_rx_full && !w_rx_pop;

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wr_ptr] <= wr_data[7:0];
        if (w_rx_push) r_rx_mem[r_rx_wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst || w_flush_tx) begin
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
            r_tx_count  <= '0;
        end else begin
            if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + PTR_ONE;
            if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + PTR_ONE;
            if (w_tx_push && !w_tx_pop)      r_tx_count <= r_tx_count + CNT_ONE;
            else if (!w_tx_push && w_tx_pop) r_tx_count <= r_tx_count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_flush_rx) begin
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
            r_rx_count  <= '0;
        end else begin
            if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + PTR_ONE;
            if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + PTR_ONE;
            if (w_rx_push && !w_rx_pop)      r_rx_count <= r_rx_count + CNT_ONE;
            else if (!w_rx_push && w_rx_pop) r_rx_count <= r_rx_count - CNT_ONE;
        end
    end

    // A new error in the clearing cycle still leaves its flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_ovf <= 1'b0;
            r_tx_ovf <= 1'b0;
            r_rx_udf <= 1'b0;
        end else begin
            r_rx_ovf <= (r_rx_ovf && !w_clr) || w_rx_ovf_evt;
            r_tx_ovf <= (r_tx_ovf && !w_clr) || w_tx_ovf_evt;
            r_rx_udf <= (r_rx_udf && !w_clr) || w_rx_udf_evt;
        end
    end

    assign w_status = {9'd0, r_rx_udf, r_tx_ovf, r_rx_ovf,
                       w_tx_full, w_tx_empty, w_rx_full, w_rx_empty,
                       8'(r_tx_count), 8'(r_rx_count)};

    always_comb begin
        w_rd_value = '0;
        case (addr[1:0])
            2'd0:    if (w_rx_pop) w_rd_value = {24'd0, r_rx_mem[r_rx_rd_ptr]};
            2'd1:    w_rd_value = w_status;
            2'd2:    w_rd_value = {29'd0, w_ie, 2'b00};
            default: w_rd_value = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)           r_rd_data <= '0;
        else if (w_access) r_rd_data <= rw ? w_rd_value : 32'd0;
    end

    assign rd_data  = (r_state == S_ACK) ? r_rd_data : 32'd0;
    assign rdy_     = (r_state != S_ACK);
    assign tx_valid = !w_tx_empty;
    assign tx_data  = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rd_ptr];

`ifdef BUS_FIFO_IRQ_EN
    logic r_ie, r_irq;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ie  <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            if (w_ctrl_wr) r_ie <= wr_data[2];
            r_irq <= r_ie && (!w_rx_empty || r_rx_ovf || r_tx_ovf);
        end
    end

    assign w_ie = r_ie;
    assign irq  = r_irq;
`else
    assign w_ie = 1'b0;
    assign irq  = 1'b0;
`endif

endmodule

// File: tb/tb_bus_fifo_slave.sv
// Bench for bus_fifo_slave: queue-based reference model checked every cycle, plus directed literal checks.
module tb_bus_fifo_slave;

    localparam int DEPTH = 16;
`ifdef BUS_FIFO_IRQ_EN
    localparam logic EXP_IRQ = 1'b1;
`else
    localparam logic EXP_IRQ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, cs_, asel_, rw, rx_valid, tx_ready;
    logic [29:0] addr;
    logic [31:0] wr_data, rd_data;
    logic        rdy_, tx_valid, irq;
    logic [7:0]  rx_data, tx_data;

    bus_fifo_slave #(.DEPTH(DEPTH), .AW(4)) dut (
        .clk(clk), .rst(rst), .cs_(cs_), .asel_(asel_), .rw(rw), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .rdy_(rdy_),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    logic        m_ack, m_irq, m_ie, m_rx_ovf, m_tx_ovf, m_rx_udf;
    logic [31:0] m_rd;

    int   txn, rxn;
    logic acc, tx_pop, tx_push, rx_pop, rx_push, fl_tx, fl_rx, clr;
    logic e_udf, e_tovf, e_rovf, irq_n;
    logic [31:0] rdv;

    always @(posedge clk) begin
        if (rst) begin
            tx_q.delete(); rx_q.delete();
            m_ack = 0; m_irq = 0; m_ie = 0; m_rd = 0;
            m_rx_ovf = 0; m_tx_ovf = 0; m_rx_udf = 0;
        end else begin
            txn = tx_q.size(); rxn = rx_q.size();
            irq_n  = m_ie && (rxn != 0 || m_rx_ovf || m_tx_ovf);
            acc    = !m_ack && !cs_ && !asel_;
            tx_pop = (txn != 0) && tx_ready;
            tx_push = 0; rx_pop = 0; rx_push = 0; fl_tx = 0; fl_rx = 0; clr = 0;
            e_udf = 0; e_tovf = 0; e_rovf = 0; rdv = 0;
            if (acc && rw) begin
                case (addr[1:0])
                    2'd0: if (rxn == 0) e_udf = 1;
                          else begin rx_pop = 1; rdv = {24'd0, rx_q[0]}; end
                    2'd1: rdv = {9'd0, m_rx_udf, m_tx_ovf, m_rx_ovf, txn == DEPTH, txn == 0,
                                 rxn == DEPTH, rxn == 0, 8'(txn), 8'(rxn)};
                    2'd2: rdv = m_ie ? 32'd4 : 32'd0;
                    default: rdv = 0;
                endcase
            end else if (acc) begin
                if (addr[1:0] == 2'd0) begin
                    if (txn < DEPTH || tx_pop) tx_push = 1; else e_tovf = 1;
                end else if (addr[1:0] == 2'd2) begin
                    fl_tx = wr_data[0]; fl_rx = wr_data[1]; clr = wr_data[3];
`ifdef BUS_FIFO_IRQ_EN
                    m_ie = wr_data[2];
`endif
                end
            end
            if (rx_valid && !fl_rx) begin
                if (rxn < DEPTH || rx_pop) rx_push = 1; else e_rovf = 1;
            end
            if (tx_pop)  void'(tx_q.pop_front());
            if (tx_push) tx_q.push_back(wr_data[7:0]);
            if (fl_tx)   tx_q.delete();
            if (rx_pop)  void'(rx_q.pop_front());
            if (rx_push) rx_q.push_back(rx_data);
            if (fl_rx)   rx_q.delete();
            if (clr) begin m_rx_ovf = 0; m_tx_ovf = 0; m_rx_udf = 0; end
            m_rx_ovf = m_rx_ovf | e_rovf;
            m_tx_ovf = m_tx_ovf | e_tovf;
            m_rx_udf = m_rx_udf | e_udf;
            m_ack = acc; m_rd = rdv; m_irq = irq_n;
        end
    end

    int   total = 0;
    int   bad = 0;
    logic chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [7:0] exp_txd;
        exp_txd = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
        chk("rdy_", 32'(rdy_), 32'(!m_ack));
        chk("rd_data", rd_data, m_ack ? m_rd : 32'h0);
        chk("tx_valid", 32'(tx_valid), 32'(tx_q.size() != 0));
        chk("tx_data", 32'(tx_data), 32'(exp_txd));
        chk("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (chk_en) check_outputs();
    endtask

    task automatic bus(input logic r, input logic [1:0] a, input logic [31:0] d,
                       output logic [31:0] q);
        cs_ = 0; asel_ = 0; rw = r; addr = {28'd0, a}; wr_data = d;
        tick();
        cs_ = 1; asel_ = 1;
        q = rd_data;
        chk("rdy_ack", 32'(rdy_), 32'd0);
        tick();
    endtask

    logic [31:0] q;
    int          bias;

    initial begin
        rst = 1; cs_ = 1; asel_ = 1; rw = 0; addr = 0; wr_data = 0;
        rx_valid = 0; rx_data = 0; tx_ready = 0;
        @(posedge clk); @(negedge clk);
        chk_en = 1;
        tick();
        chk("rst_rdy_", 32'(rdy_), 32'd1);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        rst = 0;
        tick();

        bus(1, 2'd1, 0, q);
        chk("status_reset", q, 32'h0005_0000);
        chk("rdy_after_ack", 32'(rdy_), 32'd1);

        bus(0, 2'd0, 32'h41, q);
        bus(0, 2'd0, 32'h42, q);
        bus(1, 2'd1, 0, q);
        chk("status_tx2", q, 32'h0001_0200);
        chk("tx_head_41", 32'(tx_data), 32'h41);
        tx_ready = 1;
        tick();
        chk("tx_head_42", 32'(tx_data), 32'h42);
        tick();
        chk("tx_drained", 32'(tx_valid), 32'd0);
        tx_ready = 0;

        for (int i = 0; i < 17; i++) begin
            rx_valid = 1; rx_data = 8'(i);
            tick();
        end
        rx_valid = 0;
        bus(1, 2'd1, 0, q);
        chk("status_rx_full", q, 32'h0016_0010);

        // Pop and push together while full: count holds, old head returned
        cs_ = 0; asel_ = 0; rw = 1; addr = 0; rx_valid = 1; rx_data = 8'hAA;
        tick();
        rx_valid = 0; cs_ = 1; asel_ = 1;
        chk("pop_push_head", rd_data, 32'h0);
        tick();
        bus(1, 2'd1, 0, q);
        chk("status_still_full", q, 32'h0016_0010);
        for (int i = 1; i < 16; i++) begin
            bus(1, 2'd0, 0, q);
            chk("rx_read", q, 32'(i));
        end
        bus(1, 2'd0, 0, q);
        chk("rx_read_aa", q, 32'hAA);
        bus(1, 2'd0, 0, q);
        chk("rx_read_empty", q, 32'h0);
        bus(1, 2'd1, 0, q);
        chk("status_udf", q, 32'h0055_0000);

        for (int i = 0; i < 17; i++) bus(0, 2'd0, 32'h50 + 32'(i), q);
        bus(1, 2'd1, 0, q);
        chk("status_tx_ovf", q, 32'h0079_1000);
        chk("tx_head_50", 32'(tx_data), 32'h50);
        rx_valid = 1; rx_data = 8'h11;
        tick(); tick();
        rx_valid = 0;
        bus(0, 2'd2, 32'h0000_000B, q);
        bus(1, 2'd1, 0, q);
        chk("status_cleared", q, 32'h0005_0000);
        chk("tx_flushed", 32'(tx_valid), 32'd0);

        bus(0, 2'd2, 32'h4, q);
        bus(1, 2'd2, 0, q);
        chk("ctrl_ie", q, EXP_IRQ ? 32'h4 : 32'h0);
        rx_valid = 1; rx_data = 8'h77;
        tick();
        rx_valid = 0;
        chk("irq_not_yet", 32'(irq), 32'd0);
        tick();
        chk("irq_raised", 32'(irq), 32'(EXP_IRQ));
        bus(1, 2'd0, 0, q);
        chk("rx_read_77", q, 32'h77);
        chk("irq_dropped", 32'(irq), 32'd0);

        bus(1, 2'd3, 0, q);
        chk("reserved_read", q, 32'h0);
        bus(0, 2'd1, 32'hFFFF_FFFF, q);
        bus(0, 2'd3, 32'hFFFF_FFFF, q);
        bus(1, 2'd1, 0, q);
        chk("status_ro", q, 32'h0005_0000);
        bus(0, 2'd2, 32'h0, q);

        // Reset while the ACK is in flight
        cs_ = 0; asel_ = 0; rw = 1; addr = 1;
        tick();
        cs_ = 1; asel_ = 1; rst = 1;
        tick();
        chk("rst_in_ack", 32'(rdy_), 32'd1);
        rst = 0;
        tick();

        for (int c = 0; c < 4000; c++) begin
            bias = (c / 400) % 2;
            rx_valid = ($urandom_range(0, 99) < (bias == 1 ? 70 : 5));
            rx_data  = 8'($urandom);
            tx_ready = ($urandom_range(0, 99) < (bias == 1 ? 10 : 80));
            cs_      = ($urandom_range(0, 99) >= 70);
            asel_    = ($urandom_range(0, 9) == 0);
            rw       = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: addr = {28'($urandom), 2'd0};
                6, 7:             addr = {28'($urandom), 2'd1};
                8:                addr = {28'($urandom), 2'd2};
                default:          addr = {28'($urandom), 2'd3};
            endcase
            wr_data = $urandom;
            if (addr[1:0] == 2'd2 && $urandom_range(0, 7) != 0) wr_data[1:0] = 2'b00;
            if (addr[1:0] == 2'd2 && $urandom_range(0, 3) != 0) wr_data[3] = 1'b0;
            rst = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 0; cs_ = 1; asel_ = 1; rx_valid = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
